// File: rtl/strela_csr_ctrl.sv
// CGRA control/status registers: per-node DMA descriptors, load/execute sequencer, sticky status, saturating counters.
// Optional interrupt output and IRQ_EN register at 0x10 when STRELA_CSR_IRQ_EN is defined.
package strela_csr_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module strela_csr_ctrl #(
    parameter type reg_req_t        = strela_csr_pkg::reg_req_t,
    parameter type reg_rsp_t        = strela_csr_pkg::reg_rsp_t,
    parameter int  INPUT_NODES_NUM  = 4,
    parameter int  OUTPUT_NODES_NUM = 4,
    parameter int  CNT_WIDTH        = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  reg_req_t                           reg_req_i,
    output reg_rsp_t                           reg_rsp_o,
    output logic [INPUT_NODES_NUM-1:0][31:0]   data_input_addr_o,
    output logic [INPUT_NODES_NUM-1:0][15:0]   data_input_size_o,
    output logic [INPUT_NODES_NUM-1:0][15:0]   data_input_stride_o,
    output logic [OUTPUT_NODES_NUM-1:0][31:0]  data_output_addr_o,
    output logic [OUTPUT_NODES_NUM-1:0][15:0]  data_output_size_o,
    output logic [31:0]                        data_config_addr_o,
    output logic [15:0]                        data_config_size_o,
    output logic                               load_configuration_o,
    output logic                               start_execution_o,
    output logic                               clear_cgra_o,
    input  logic                               done_config_i,
    input  logic                               done_exec_output_i,
    input  logic                               stall_i,
`ifdef STRELA_CSR_IRQ_EN
    output logic                               irq_o,
`endif
    output logic                               busy_o
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CONFIG = 2'd1, S_EXEC = 2'd2} state_t;

    state_t                            r_state;
    logic [2:0]                        r_status;
    logic                              r_load_p, r_start_p, r_clear_p;
    logic [CNT_WIDTH-1:0]              r_cnt_load, r_cnt_exec, r_cnt_stall;
    logic [INPUT_NODES_NUM-1:0][31:0]  r_in_addr;
    logic [INPUT_NODES_NUM-1:0][15:0]  r_in_size, r_in_stride;
    logic [OUTPUT_NODES_NUM-1:0][31:0] r_out_addr;
    logic [OUTPUT_NODES_NUM-1:0][15:0] r_out_size;
    logic [31:0]                       r_cfg_addr;
    logic [15:0]                       r_cfg_size;
`ifdef STRELA_CSR_IRQ_EN
    logic [2:0]                        r_irq_en;
    logic [2:0]                        w_irq_en_nxt;
    logic                              r_irq;
`endif

    logic [7:0]  w_off;
    logic [2:0]  w_idx;
    logic        w_aligned, w_wr, w_mapped, w_is_desc, w_desc_wr;
    logic [31:0] w_rdata;
    logic        w_ctrl_wr, w_stat_wr, w_load, w_start, w_clear, w_idle, w_drop;
    logic [2:0]  w_status_nxt;

    function automatic logic [31:0] f_be32(input logic [31:0] i_old, input logic [31:0] i_new,
                                           input logic [3:0] i_be);
        logic [31:0] v;
        for (int b = 0; b < 4; b++) v[8*b +: 8] = i_be[b] ? i_new[8*b +: 8] : i_old[8*b +: 8];
        return v;
    endfunction

    function automatic logic [15:0] f_be16(input logic [15:0] i_old, input logic [15:0] i_new,
                                           input logic [1:0] i_be);
        logic [15:0] v;
        for (int b = 0; b < 2; b++) v[8*b +: 8] = i_be[b] ? i_new[8*b +: 8] : i_old[8*b +: 8];
        return v;
    endfunction

    assign w_off     = reg_req_i.addr[7:0];
    assign w_idx     = w_off[5:3];
    assign w_aligned = (reg_req_i.addr[31:8] == 24'd0) && (reg_req_i.addr[1:0] == 2'd0);
    assign w_wr      = reg_req_i.valid & reg_req_i.write;
    assign w_idle    = (r_state == S_IDLE);

    always_comb begin
        w_rdata   = '0;
        w_mapped  = 1'b0;
        w_is_desc = 1'b0;
        if (w_aligned) begin
            case (w_off)
                8'h00: w_mapped = 1'b1;
                8'h04: begin w_mapped = 1'b1; w_rdata = {26'd0, r_state, 1'b0, r_status}; end
                8'h08: begin w_mapped = 1'b1; w_is_desc = 1'b1; w_rdata = r_cfg_addr; end
                8'h0C: begin w_mapped = 1'b1; w_is_desc = 1'b1; w_rdata = {16'd0, r_cfg_size}; end
`ifdef STRELA_CSR_IRQ_EN
                8'h10: begin w_mapped = 1'b1; w_rdata = {29'd0, r_irq_en}; end
`endif
                8'hC0: begin w_mapped = 1'b1; w_rdata = 32'(r_cnt_load); end
                8'hC4: begin w_mapped = 1'b1; w_rdata = 32'(r_cnt_exec); end
                8'hC8: begin w_mapped = 1'b1; w_rdata = 32'(r_cnt_stall); end
                default: begin
                    // Node slots beyond the configured count never match and stay unmapped.
                    for (int i = 0; i < INPUT_NODES_NUM; i++) begin
                        if (w_off[7:6] == 2'b01 && w_idx == i[2:0]) begin
                            w_mapped  = 1'b1;
                            w_is_desc = 1'b1;
                            w_rdata   = w_off[2] ? {r_in_stride[i], r_in_size[i]} : r_in_addr[i];
                        end
                    end
                    for (int j = 0; j < OUTPUT_NODES_NUM; j++) begin
                        if (w_off[7:6] == 2'b10 && w_idx == j[2:0]) begin
                            w_mapped  = 1'b1;
                            w_is_desc = 1'b1;
                            w_rdata   = w_off[2] ? {16'd0, r_out_size[j]} : r_out_addr[j];
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.rdata = w_rdata;
        reg_rsp_o.error = reg_req_i.valid & (~w_mapped | (reg_req_i.write & w_is_desc & ~w_idle));
        reg_rsp_o.ready = 1'b1;
    end

    assign w_desc_wr = w_wr & w_mapped & w_is_desc & w_idle;
    assign w_ctrl_wr = w_wr & w_aligned & (w_off == 8'h00);
    assign w_stat_wr = w_wr & w_aligned & (w_off == 8'h04);
    assign w_load    = w_ctrl_wr & reg_req_i.wdata[0];
    assign w_start   = w_ctrl_wr & reg_req_i.wdata[1];
    assign w_clear   = w_ctrl_wr & reg_req_i.wdata[2];
    assign w_drop    = (w_load | w_start) & (w_clear | ~w_idle | (w_load & w_start));

    // Sticky sets are applied after the W1C so a same-cycle set survives.
    always_comb begin
        w_status_nxt = r_status;
        if (w_stat_wr) w_status_nxt = r_status & ~reg_req_i.wdata[2:0];
        if (r_state == S_CONFIG && done_config_i) w_status_nxt[0] = 1'b1;
        if (r_state == S_EXEC && done_exec_output_i) w_status_nxt[1] = 1'b1;
        if (w_drop) w_status_nxt[2] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cfg_addr  <= '0;
            r_cfg_size  <= '0;
            r_in_addr   <= '0;
            r_in_size   <= '0;
            r_in_stride <= '0;
            r_out_addr  <= '0;
            r_out_size  <= '0;
        end else if (w_desc_wr) begin
            if (w_off == 8'h08) r_cfg_addr <= f_be32(r_cfg_addr, reg_req_i.wdata, reg_req_i.wstrb);
            if (w_off == 8'h0C) r_cfg_size <= f_be16(r_cfg_size, reg_req_i.wdata[15:0], reg_req_i.wstrb[1:0]);
            for (int i = 0; i < INPUT_NODES_NUM; i++) begin
                if (w_off[7:6] == 2'b01 && w_idx == i[2:0]) begin
                    if (w_off[2]) begin
                        r_in_size[i]   <= f_be16(r_in_size[i], reg_req_i.wdata[15:0], reg_req_i.wstrb[1:0]);
                        r_in_stride[i] <= f_be16(r_in_stride[i], reg_req_i.wdata[31:16], reg_req_i.wstrb[3:2]);
                    end else begin
                        r_in_addr[i] <= f_be32(r_in_addr[i], reg_req_i.wdata, reg_req_i.wstrb);
                    end
                end
            end
            for (int j = 0; j < OUTPUT_NODES_NUM; j++) begin
                if (w_off[7:6] == 2'b10 && w_idx == j[2:0]) begin
                    if (w_off[2]) r_out_size[j] <= f_be16(r_out_size[j], reg_req_i.wdata[15:0], reg_req_i.wstrb[1:0]);
                    else          r_out_addr[j] <= f_be32(r_out_addr[j], reg_req_i.wdata, reg_req_i.wstrb);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_status    <= '0;
            r_load_p    <= 1'b0;
            r_start_p   <= 1'b0;
            r_clear_p   <= 1'b0;
            r_cnt_load  <= '0;
            r_cnt_exec  <= '0;
            r_cnt_stall <= '0;
        end else begin
            r_load_p  <= 1'b0;
            r_start_p <= 1'b0;
            r_clear_p <= 1'b0;
            r_status  <= w_status_nxt;
            case (r_state)
                S_CONFIG: begin
                    if (r_cnt_load != '1) r_cnt_load <= r_cnt_load + CNT_WIDTH'(1);
                    if (done_config_i) r_state <= S_IDLE;
                end
                S_EXEC: begin
                    if (r_cnt_exec != '1) r_cnt_exec <= r_cnt_exec + CNT_WIDTH'(1);
                    if (stall_i && r_cnt_stall != '1) r_cnt_stall <= r_cnt_stall + CNT_WIDTH'(1);
                    if (done_exec_output_i) r_state <= S_IDLE;
                end
                default: ;
            endcase
            if (w_clear) begin
                r_clear_p <= 1'b1;
                r_state   <= S_IDLE;
            end else if (w_idle && w_load) begin
                r_load_p   <= 1'b1;
                r_state    <= S_CONFIG;
                r_cnt_load <= '0;
            end else if (w_idle && w_start) begin
                r_start_p   <= 1'b1;
                r_state     <= S_EXEC;
                r_cnt_exec  <= '0;
                r_cnt_stall <= '0;
            end
        end
    end

`ifdef STRELA_CSR_IRQ_EN
    assign w_irq_en_nxt = (w_wr && w_aligned && w_off == 8'h10) ? reg_req_i.wdata[2:0] : r_irq_en;

    // Built from next-state values so a W1C drops the interrupt on the following cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_irq_en <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_irq_en <= w_irq_en_nxt;
            r_irq    <= |(w_status_nxt & w_irq_en_nxt);
        end
    end

    assign irq_o = r_irq;
`endif

    assign data_input_addr_o    = r_in_addr;
    assign data_input_size_o    = r_in_size;
    assign data_input_stride_o  = r_in_stride;
    assign data_output_addr_o   = r_out_addr;
    assign data_output_size_o   = r_out_size;
    assign data_config_addr_o   = r_cfg_addr;
    assign data_config_size_o   = r_cfg_size;
    assign load_configuration_o = r_load_p;
    assign start_execution_o    = r_start_p;
    assign clear_cgra_o         = r_clear_p;
    assign busy_o               = (r_state != S_IDLE);
endmodule

// File: tb/tb_strela_csr_ctrl.sv
// Bench for strela_csr_ctrl: directed scenarios plus random bus/CTRL traffic against a behavioural register model.
module tb_strela_csr_ctrl;
    localparam int     NI   = 4;
    localparam int     NO   = 4;
    localparam int     CW   = 32;
    localparam longint CMAX = (longint'(1) << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    strela_csr_pkg::reg_req_t req;
    strela_csr_pkg::reg_rsp_t rsp;
    logic [NI-1:0][31:0] in_addr;
    logic [NI-1:0][15:0] in_size, in_stride;
    logic [NO-1:0][31:0] out_addr;
    logic [NO-1:0][15:0] out_size;
    logic [31:0] cfg_addr;
    logic [15:0] cfg_size;
    logic load_p, start_p, clear_p, done_cfg, done_exec, stall, busy;
`ifdef STRELA_CSR_IRQ_EN
    logic irq;
`endif

    strela_csr_ctrl #(.INPUT_NODES_NUM(NI), .OUTPUT_NODES_NUM(NO), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst), .reg_req_i(req), .reg_rsp_o(rsp),
        .data_input_addr_o(in_addr), .data_input_size_o(in_size), .data_input_stride_o(in_stride),
        .data_output_addr_o(out_addr), .data_output_size_o(out_size),
        .data_config_addr_o(cfg_addr), .data_config_size_o(cfg_size),
        .load_configuration_o(load_p), .start_execution_o(start_p), .clear_cgra_o(clear_p),
        .done_config_i(done_cfg), .done_exec_output_i(done_exec), .stall_i(stall),
`ifdef STRELA_CSR_IRQ_EN
        .irq_o(irq),
`endif
        .busy_o(busy));

    always #5 clk = ~clk;

    // Reference model state: 0 idle, 1 loading config, 2 executing.
    int          m_state;
    logic [2:0]  m_sticky;
    longint      m_cnt [3];
    logic [31:0] m_in_addr [NI];
    logic [15:0] m_in_size [NI];
    logic [15:0] m_in_stride [NI];
    logic [31:0] m_out_addr [NO];
    logic [15:0] m_out_size [NO];
    logic [31:0] m_cfg_addr;
    logic [15:0] m_cfg_size;
    logic [2:0]  m_irq_en;
    bit          m_load, m_start, m_clear, m_irq;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          busy_cycles, n_load_seen, n_start_seen, n_clear_seen;
    logic [31:0] g_rd;
    logic        g_err;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic void m_reset();
        m_state = 0; m_sticky = '0; m_cfg_addr = '0; m_cfg_size = '0; m_irq_en = '0;
        m_load = 0; m_start = 0; m_clear = 0; m_irq = 0;
        for (int k = 0; k < 3; k++) m_cnt[k] = 0;
        for (int i = 0; i < NI; i++) begin m_in_addr[i] = '0; m_in_size[i] = '0; m_in_stride[i] = '0; end
        for (int j = 0; j < NO; j++) begin m_out_addr[j] = '0; m_out_size[j] = '0; end
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (nw & mask);
    endfunction

    function automatic longint m_inc(input longint c);
        return (c >= CMAX) ? CMAX : c + 1;
    endfunction

    function automatic void m_decode(input logic [31:0] a, output logic [31:0] rd, output bit mapped, output bit desc);
        int off;
        rd = '0; mapped = 0; desc = 0;
        if (a[1:0] != 2'b00 || a > 32'hFF) return;
        off = int'(a);
        if (off == 'h00) mapped = 1;
        else if (off == 'h04) begin mapped = 1; rd = {26'd0, 2'(m_state), 1'b0, m_sticky}; end
        else if (off == 'h08) begin mapped = 1; desc = 1; rd = m_cfg_addr; end
        else if (off == 'h0C) begin mapped = 1; desc = 1; rd = {16'd0, m_cfg_size}; end
`ifdef STRELA_CSR_IRQ_EN
        else if (off == 'h10) begin mapped = 1; rd = {29'd0, m_irq_en}; end
`endif
        else if (off >= 'hC0 && off <= 'hC8) begin mapped = 1; rd = 32'(m_cnt[(off - 'hC0) / 4]); end
        else if (off >= 'h40 && off < 'h40 + 8 * NI) begin
            mapped = 1; desc = 1;
            rd = ((off - 'h40) % 8 == 0) ? m_in_addr[(off - 'h40) / 8]
                                         : {m_in_stride[(off - 'h40) / 8], m_in_size[(off - 'h40) / 8]};
        end else if (off >= 'h80 && off < 'h80 + 8 * NO) begin
            mapped = 1; desc = 1;
            rd = ((off - 'h80) % 8 == 0) ? m_out_addr[(off - 'h80) / 8] : {16'd0, m_out_size[(off - 'h80) / 8]};
        end
    endfunction

    function automatic void m_step(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] be, input bit dc, input bit de, input bit st);
        logic [31:0] rd_dummy, t;
        bit mapped, desc, wr, drop;
        int nxt, off, n;
        logic [2:0] stk;
        m_decode(a, rd_dummy, mapped, desc);
        wr  = v && w;
        stk = m_sticky;
        if (wr && a == 32'h4) stk = stk & ~d[2:0];
        if (m_state == 1 && dc) stk[0] = 1'b1;
        if (m_state == 2 && de) stk[1] = 1'b1;
        nxt = m_state;
        if (m_state == 1) begin m_cnt[0] = m_inc(m_cnt[0]); if (dc) nxt = 0; end
        if (m_state == 2) begin
            m_cnt[1] = m_inc(m_cnt[1]);
            if (st) m_cnt[2] = m_inc(m_cnt[2]);
            if (de) nxt = 0;
        end
        m_load = 0; m_start = 0; m_clear = 0; drop = 0;
        if (wr && a == 32'h0) begin
            if (d[2]) begin m_clear = 1; nxt = 0; drop = d[0] | d[1]; end
            else if (d[0] | d[1]) begin
                if (m_state != 0) drop = 1;
                else if (d[0]) begin m_load = 1; nxt = 1; m_cnt[0] = 0; drop = d[1]; end
                else begin m_start = 1; nxt = 2; m_cnt[1] = 0; m_cnt[2] = 0; end
            end
        end
        if (drop) stk[2] = 1'b1;
        if (wr && mapped && desc && m_state == 0) begin
            off = int'(a);
            if (off == 'h08) m_cfg_addr = m_merge(m_cfg_addr, d, be);
            else if (off == 'h0C) begin t = m_merge({16'd0, m_cfg_size}, d, be); m_cfg_size = t[15:0]; end
            else if (off < 'h80) begin
                n = (off - 'h40) / 8;
                if ((off - 'h40) % 8 == 0) m_in_addr[n] = m_merge(m_in_addr[n], d, be);
                else begin t = m_merge({m_in_stride[n], m_in_size[n]}, d, be); m_in_stride[n] = t[31:16]; m_in_size[n] = t[15:0]; end
            end else begin
                n = (off - 'h80) / 8;
                if ((off - 'h80) % 8 == 0) m_out_addr[n] = m_merge(m_out_addr[n], d, be);
                else begin t = m_merge({16'd0, m_out_size[n]}, d, be); m_out_size[n] = t[15:0]; end
            end
        end
`ifdef STRELA_CSR_IRQ_EN
        if (wr && a == 32'h10) m_irq_en = d[2:0];
`endif
        m_sticky = stk;
        m_state  = nxt;
        m_irq    = |(stk & m_irq_en);
    endfunction

    // One bus cycle: drive at negedge, check combinational response, then check registered outputs after the edge.
    task automatic cyc(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input bit dc, input bit de, input bit st);
        logic [31:0] exp_rd;
        bit mapped, desc;
        req.valid = v; req.write = w; req.addr = a; req.wdata = d; req.wstrb = be;
        done_cfg = dc; done_exec = de; stall = st;
        #1;
        g_rd = rsp.rdata; g_err = rsp.error;
        m_decode(a, exp_rd, mapped, desc);
        check_eq("ready", rsp.ready, 1);
        if (v) begin
            check_eq($sformatf("error@%02h", a), g_err, (!mapped || (w && desc && m_state != 0)) ? 1 : 0);
            if (!w) check_eq($sformatf("rdata@%02h", a), g_rd, exp_rd);
        end
        m_step(v, w, a, d, be, dc, de, st);
        @(posedge clk); #1;
        check_eq("load_pulse", load_p, m_load);
        check_eq("start_pulse", start_p, m_start);
        check_eq("clear_pulse", clear_p, m_clear);
        check_eq("busy", busy, m_state != 0);
`ifdef STRELA_CSR_IRQ_EN
        check_eq("irq", irq, m_irq);
`endif
        if (busy) busy_cycles++;
        if (load_p) n_load_seen++;
        if (start_p) n_start_seen++;
        if (clear_p) n_clear_seen++;
        @(negedge clk);
        req.valid = 0; req.write = 0; done_cfg = 0; done_exec = 0; stall = 0;
    endtask

    task automatic idle(input bit dc, input bit de, input bit st);
        cyc(0, 0, 32'h0, 32'h0, 4'h0, dc, de, st);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        cyc(1, 1, a, d, be, 0, 0, 0);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(1, 0, a, 32'h0, 4'h0, 0, 0, 0);
    endtask

    task automatic check_desc();
        check_eq("cfg_addr", cfg_addr, m_cfg_addr);
        check_eq("cfg_size", cfg_size, m_cfg_size);
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("in_addr%0d", i), in_addr[i], m_in_addr[i]);
            check_eq($sformatf("in_size%0d", i), in_size[i], m_in_size[i]);
            check_eq($sformatf("in_stride%0d", i), in_stride[i], m_in_stride[i]);
        end
        for (int j = 0; j < NO; j++) begin
            check_eq($sformatf("out_addr%0d", j), out_addr[j], m_out_addr[j]);
            check_eq($sformatf("out_size%0d", j), out_size[j], m_out_size[j]);
        end
    endtask

    task automatic do_reset();
        #2; rst = 1'b1; #1;
        m_reset();
        check_eq("arst_busy", busy, 0);
        check_eq("arst_pulses", {load_p, start_p, clear_p}, 0);
        @(posedge clk); #1;
        check_eq("rst_pulses", {load_p, start_p, clear_p}, 0);
        check_desc();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] a, d;
        int r;
        req = '0; done_cfg = 0; done_exec = 0; stall = 0;
        m_reset();
        repeat (3) @(negedge clk);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_pulses", {load_p, start_p, clear_p}, 0);
        check_desc();
        rst = 1'b0;

        rd(32'h04); check_eq("status_after_reset", g_rd, 0);
        rd(32'h40); check_eq("in0_after_reset", g_rd, 0);
        rd(32'hC0); check_eq("cnt_after_reset", g_rd, 0);
        rd(32'h40 + 8 * NI); check_eq("oob_node_err", g_err, 1);

        wr(32'h44, 32'h0004_0050, 4'b0011);
        check_eq("in_size0_low_be", in_size[0], 16'h0050);
        check_eq("in_stride0_low_be", in_stride[0], 16'h0000);
        wr(32'h44, 32'h0004_0050, 4'b1111);
        check_eq("in_stride0_full_be", in_stride[0], 16'h0004);

        busy_cycles = 0; n_load_seen = 0;
        wr(32'h00, 32'h1, 4'hF);
        repeat (10) idle(0, 0, 0);
        idle(1, 0, 0);
        check_eq("load_busy_len", busy_cycles, 11);
        check_eq("load_pulse_count", n_load_seen, 1);
        rd(32'hC0); check_eq("load_cycles", g_rd, 11);
        rd(32'h04); check_eq("status_cfg_done", g_rd, 32'h1);
        wr(32'h04, 32'h1, 4'hF);
        rd(32'h04); check_eq("status_w1c", g_rd, 0);

        wr(32'h00, 32'h2, 4'hF);
        for (int i = 0; i < 20; i++) idle(0, 0, i == 3 || i == 7 || i == 15);
        idle(0, 1, 0);
        rd(32'hC4); check_eq("exec_cycles", g_rd, 21);
        rd(32'hC8); check_eq("stall_cycles", g_rd, 3);
        rd(32'h04); check_eq("status_exec_done", g_rd, 32'h2);

        n_start_seen = 0; n_load_seen = 0; n_clear_seen = 0;
        wr(32'h00, 32'h2, 4'hF);
        wr(32'h00, 32'h2, 4'hF);
        check_eq("restart_in_exec_pulses", n_start_seen, 1);
        rd(32'h04); check_eq("status_dropped_exec", g_rd, 32'h26);
        wr(32'h00, 32'h7, 4'hF);
        check_eq("clear_pulse_count", n_clear_seen, 1);
        check_eq("clear_no_load_start", n_load_seen + n_start_seen, 1);
        rd(32'h04); check_eq("status_after_clear", g_rd, 32'h06);

        wr(32'h04, 32'h7, 4'hF);
        wr(32'h40, 32'h1000_0000, 4'hF);
        wr(32'h00, 32'h1, 4'hF);
        wr(32'h40, 32'hDEAD_BEEF, 4'hF);
        check_eq("desc_wr_busy_err", g_err, 1);
        check_eq("desc_wr_busy_kept", in_addr[0], 32'h1000_0000);
        idle(1, 0, 0);

        for (int it = 0; it < 1500; it++) begin
            r = $urandom_range(0, 99);
            a = 32'($urandom_range(0, 67)) * 4;
            if ($urandom_range(0, 19) == 0) a = a | 32'h1;
            d = $urandom;
            if (it == 800) do_reset();
            if (r < 30) idle($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
            else if (r < 55) cyc(1, 0, a, d, 4'h0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
            else if (r < 80) cyc(1, 1, a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
            else if (r < 90) cyc(1, 1, 32'h0, 32'($urandom_range(0, 7)), 4'hF, $urandom_range(0, 15) == 0, 0, $urandom_range(0, 1) == 1);
            else cyc(1, 1, 32'h4, 32'($urandom_range(0, 7)), 4'hF, 0, $urandom_range(0, 15) == 0, 0);
            if (it % 100 == 99) check_desc();
        end

        wr(32'h00, 32'h4, 4'hF);
        wr(32'h00, 32'h2, 4'hF);
        repeat (5) idle(0, 0, 1);
        do_reset();
        rd(32'hC4); check_eq("exec_cnt_after_midrun_reset", g_rd, 0);
        rd(32'h04); check_eq("status_after_midrun_reset", g_rd, 0);

`ifdef STRELA_CSR_IRQ_EN
        wr(32'h10, 32'h2, 4'hF);
        wr(32'h00, 32'h2, 4'hF);
        repeat (3) idle(0, 0, 0);
        idle(0, 1, 0);
        check_eq("irq_on_exec_done", irq, 1);
        wr(32'h04, 32'h2, 4'hF);
        check_eq("irq_after_w1c", irq, 0);
`endif

        check_desc();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule
